// File: rtl/alu_share_ctrl_if.sv
// alu_share_ctrl_if: two-port request/response bus between issue logic and the ALU sharing controller
interface alu_share_ctrl_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [5:0]  req_op0;
  logic [5:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_nzcv;
  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_nzcv
  );
  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_nzcv
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU between two requesters, with icc ownership
module alu_share_ctrl (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus,
  output logic [5:0]        alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic              alu_ci,
  input  logic [31:0]       alu_y,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              icc_we,
  input  logic [3:0]        icc_wdata,
  output logic [3:0]        icc
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state, state_n;
  logic        last_grant;
  logic        owner;
  logic [5:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rsp_y;
  logic [3:0]  rsp_nzcv;
  logic [1:0]  gnt;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic        accept;
  logic        sel;
  logic        rsp_ack;
  logic        cc_op;
  logic [3:0]  flags;
  always_comb begin
    gnt[0]    = bus.req_valid[0] & (~bus.req_valid[1] | last_grant);
    gnt[1]    = bus.req_valid[1] & (~bus.req_valid[0] | ~last_grant);
    req_ready = (state == IDLE) ? gnt : 2'b00;
    accept    = |(bus.req_valid & req_ready);
    sel       = req_ready[1];
    rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    rsp_ack   = (state == RESP) & bus.rsp_ready[owner];
    cc_op     = (op_q[5:4] == 2'b01);
    flags     = {alu_n, alu_z, alu_c, alu_v};
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? EXEC : IDLE;
      EXEC:    state_n = RESP;
      RESP:    state_n = rsp_ack ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_y      <= '0;
      rsp_nzcv   <= '0;
      icc        <= '0;
    end else begin
      if (accept) begin
        op_q       <= sel ? bus.req_op1 : bus.req_op0;
        a_q        <= sel ? bus.req_a1 : bus.req_a0;
        b_q        <= sel ? bus.req_b1 : bus.req_b0;
        owner      <= sel;
        last_grant <= sel;
      end
      if (state == EXEC) begin
        rsp_y    <= alu_y;
        rsp_nzcv <= cc_op ? flags : icc;
      end
      // an external WRPSR-style write overrides a same-edge cc update
      if (icc_we) icc <= icc_wdata;
      else if (state == EXEC && cc_op) icc <= flags;
    end
  end
  assign alu_op        = op_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_ci        = op_q[3] & icc[1];
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_y     = rsp_y;
  assign bus.rsp_nzcv  = rsp_nzcv;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, latency, icc handling and reset abort
module tb_alu_share_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        alu_ci, alu_n, alu_z, alu_c, alu_v;
  logic        icc_we;
  logic [3:0]  icc_wdata, icc;
  logic [32:0] s;
  int          n_asserts = 0;
  int          n_fail = 0;
  alu_share_ctrl_if bus();
  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .icc_we(icc_we), .icc_wdata(icc_wdata), .icc(icc)
  );
  always #5 clk = ~clk;
  // behavioural stand-in for the shared ALU: op[2] selects subtract, carry-in always honoured
  always_comb begin
    s     = alu_op[2] ? {1'b0, alu_a} - {1'b0, alu_b} - {32'd0, alu_ci}
                      : {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_ci};
    alu_y = s[31:0];
    alu_n = s[31];
    alu_z = (s[31:0] == 32'd0);
    alu_c = s[32];
    alu_v = alu_op[2] ? (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31])
                      : (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input int p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end else begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end
  endtask
  task automatic do_op(input int p, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [3:0] wd, input logic eci,
                       input logic [31:0] ey, input logic [3:0] en, input logic [3:0] ei);
    drive(p, op, a, b);
    bus.req_valid = 2'b01 << p;
    #1 chk("req_ready_idle", bus.req_ready, 2'b01 << p);
    @(negedge clk);
    bus.req_valid = 2'b00;
    drive(p, 6'h3f, 32'd0, 32'd0);
    icc_we = we; icc_wdata = wd;
    #1 chk("req_ready_exec", bus.req_ready, 2'b00);
    chk("rsp_valid_exec", bus.rsp_valid, 2'b00);
    chk("alu_op", alu_op, op);
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_ci", alu_ci, eci);
    @(negedge clk);
    icc_we = 1'b0;
    #1 chk("rsp_valid", bus.rsp_valid, 2'b01 << p);
    chk("rsp_y", bus.rsp_y, ey);
    chk("rsp_nzcv", bus.rsp_nzcv, en);
    chk("icc", icc, ei);
    bus.rsp_ready = 2'b01 << p;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1 chk("rsp_valid_done", bus.rsp_valid, 2'b00);
  endtask
  initial begin
    rst_n = 1'b0; icc_we = 1'b0; icc_wdata = 4'h0;
    bus.req_valid = 2'b00; bus.rsp_ready = 2'b00;
    drive(0, 6'd0, 32'd0, 32'd0);
    drive(1, 6'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1 chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_icc", icc, 4'h0);
    chk("rst_rsp_y", bus.rsp_y, 32'd0);
    chk("rst_alu_op", alu_op, 6'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(0, 6'b010100, 32'd7, 32'd1, 1'b0, 4'h0, 1'b0, 32'd6, 4'b0000, 4'b0000);
    do_op(1, 6'b010000, 32'h7fffffff, 32'd1, 1'b0, 4'h0, 1'b0, 32'h80000000, 4'b1001, 4'b1001);
    do_op(0, 6'b000000, 32'd1, 32'd1, 1'b0, 4'h0, 1'b0, 32'd2, 4'b1001, 4'b1001);
    do_op(0, 6'b010000, 32'hffffffff, 32'd1, 1'b0, 4'h0, 1'b0, 32'd0, 4'b0110, 4'b0110);
    do_op(1, 6'b001000, 32'd2, 32'd3, 1'b0, 4'h0, 1'b1, 32'd6, 4'b0110, 4'b0110);
    // stalled response: non-owner rsp_ready ignored, waiting port 1 not granted until IDLE
    drive(0, 6'b000000, 32'd5, 32'd6);
    bus.req_valid = 2'b01;
    #1 chk("stall_grant0", bus.req_ready, 2'b01);
    @(negedge clk);
    drive(1, 6'b000000, 32'd1, 32'd1);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_rsp_valid", bus.rsp_valid, 2'b01);
      chk("stall_rsp_y", bus.rsp_y, 32'd11);
      chk("stall_req_ready", bus.req_ready, 2'b00);
      @(negedge clk);
    end
    bus.rsp_ready = 2'b01;
    #1 chk("ack_req_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1 chk("after_ack_rsp_valid", bus.rsp_valid, 2'b00);
    chk("after_ack_grant1", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1 chk("p1_alu_a", alu_a, 32'd1);
    @(negedge clk);
    #1 chk("p1_rsp_valid", bus.rsp_valid, 2'b10);
    chk("p1_rsp_y", bus.rsp_y, 32'd2);
    chk("p1_rsp_nzcv", bus.rsp_nzcv, 4'b0110);
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    // external icc write on the EXEC edge of a subcc wins over the ALU flags
    do_op(0, 6'b010100, 32'd7, 32'd1, 1'b1, 4'b1111, 1'b0, 32'd6, 4'b0000, 4'b1111);
    // round robin with both ports valid from reset
    rst_n = 1'b0;
    drive(0, 6'b000000, 32'd1, 32'd1);
    drive(1, 6'b000000, 32'd1, 32'd1);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    #1 chk("rr_rst_icc", icc, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1 chk("rr_req_ready", bus.req_ready, (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01));
      chk("rr_rsp_valid", bus.rsp_valid, (c % 3 != 2) ? 2'b00 : (((c / 3) % 2 == 1) ? 2'b10 : 2'b01));
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    // reset during EXEC aborts the op and clears icc
    icc_we = 1'b1; icc_wdata = 4'b1010;
    @(negedge clk);
    icc_we = 1'b0;
    #1 chk("preload_icc", icc, 4'b1010);
    drive(0, 6'b010000, 32'hffffffff, 32'd1);
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1 chk("abort_icc", icc, 4'h0);
    chk("abort_rsp_valid", bus.rsp_valid, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1 chk("abort_no_rsp", bus.rsp_valid, 2'b00);
      chk("abort_icc_hold", icc, 4'h0);
    end
    bus.req_valid = 2'b01;
    #1 chk("abort_idle_grant", bus.req_ready, 2'b01);
    bus.req_valid = 2'b00;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
